// File: rtl/ahblite_cmd_master.sv
// AHB-Lite initiator: turns single-word local commands into non-burst AHB-Lite transfers.
// Handles wait states, two-cycle ERROR responses and hung slaves (timeout), with a one-cycle response strobe.
module ahblite_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);

  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Value the counter holds just before the final low cycle that trips the timeout.
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic          accept, legal, timeout_hit;
  logic          rsp_fire, rsp_err_next, rsp_timeout_next;
  logic [31:0]   rsp_rdata_next;

  assign cmd_ready   = (state == ST_IDLE);
  assign accept      = cmd_valid & cmd_ready;
  assign legal       = (cmd_size == 3'd0)
                     | ((cmd_size == 3'd1) & ~cmd_addr[0])
                     | ((cmd_size == 3'd2) & (cmd_addr[1:0] == 2'b00));
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && !HREADY && (wait_cnt == CNT_LAST);

  assign HTRANS    = (state == ST_ADDR) ? 2'b10 : 2'b00;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next       = state;
    rsp_fire         = 1'b0;
    rsp_err_next     = 1'b0;
    rsp_timeout_next = 1'b0;
    rsp_rdata_next   = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (legal) begin
            state_next = ST_ADDR;
          end else begin
            rsp_fire     = 1'b1;
            rsp_err_next = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (HREADY) state_next = ST_DATA;
      end
      ST_DATA: begin
        // Completion takes priority over a timeout landing on the same edge.
        if (HREADY) begin
          state_next = ST_IDLE;
          rsp_fire   = 1'b1;
          if (HRESP)        rsp_err_next   = 1'b1;
          else if (!HWRITE) rsp_rdata_next = HRDATA;
        end else if (timeout_hit) begin
          state_next       = ST_DRAIN;
          rsp_fire         = 1'b1;
          rsp_timeout_next = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (HREADY) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HADDR  <= '0;
      HSIZE  <= 3'b010;
      HWRITE <= 1'b0;
      HWDATA <= '0;
    end else if (accept) begin
      HADDR  <= cmd_addr;
      HSIZE  <= cmd_size;
      HWRITE <= cmd_write;
      HWDATA <= cmd_wdata;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt <= '0;
    end else if ((state == ST_ADDR) && HREADY) begin
      wait_cnt <= '0;
    end else if ((state == ST_DATA) && !HREADY && (TIMEOUT_CYCLES != 0)) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid   <= rsp_fire;
      rsp_err     <= rsp_err_next;
      rsp_timeout <= rsp_timeout_next;
      rsp_rdata   <= rsp_rdata_next;
    end
  end

endmodule

// File: doc/ahblite_cmd_master.md
Name: ahblite_cmd_master

Overview:
- AHB-Lite initiator: turns single-word commands from a local controller (e.g. the M0 config sequencer or a test driver) into non-burst AHB-Lite transfers.
- Drives the bus-side slaves in the AHB subsystem (control-register slaves such as the image-pipeline enable registers).
- Handles wait states and two-cycle ERROR responses, guards against hung slaves with a timeout, and returns read data and status on a one-cycle response strobe.

Parameters:
- TIMEOUT_CYCLES, 256: max consecutive data-phase cycles with HREADY=0 before timeout; 0 disables the timeout.
- HPROT_VAL, 4'b0011: constant driven on HPROT (non-cacheable, privileged data).

Ports:
- HCLK  in  1  bus clock
- HRESETn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at HCLK edge
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  32  byte address
- cmd_size  in  3  HSIZE encoding; only 0/1/2 legal
- cmd_wdata  in  32  write data
- rsp_valid  out  1  one-cycle response strobe; no backpressure
- rsp_rdata  out  32  read data (0 for writes/errors)
- rsp_err  out  1  slave ERROR or rejected command
- rsp_timeout  out  1  timeout response
- HADDR  out  32
- HTRANS  out  2
- HSIZE  out  3
- HWRITE  out  1
- HWDATA  out  32
- HBURST  out  3  constant 3'b000 (SINGLE)
- HPROT  out  4  constant HPROT_VAL
- HMASTLOCK  out  1  constant 0
- HREADY  in  1  bus ready (from interconnect mux)
- HRDATA  in  32
- HRESP  in  1

Behaviour:
- Reset values: state=IDLE, HTRANS=2'b00, HADDR=0, HSIZE=3'b010, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, timeout counter=0. cmd_ready is decoded from state (=1 in IDLE).
- States: IDLE, ADDR, DATA, DRAIN.
- IDLE:
  - cmd_ready=1, HTRANS=IDLE.
  - On handshake, latch write/addr/size/wdata.
  - Legality check at accept: size>2, size=1 with addr[0]=1, or size=2 with addr[1:0]!=0 → no bus transfer; next cycle rsp_valid=1, rsp_err=1; stay IDLE.
  - Legal command → ADDR.
- ADDR:
  - HTRANS=NONSEQ (2'b10); HADDR/HSIZE/HWRITE from latch.
  - Held stable until an edge with HREADY=1, then → DATA. Timeout counter not running.
- DATA:
  - HTRANS=IDLE; HWDATA=latched wdata (held for the whole data phase).
  - Each cycle with HREADY=0 increments the counter.
  - Edge with HREADY=1, HRESP=0 → rsp_valid next cycle; rsp_rdata=HRDATA sampled at that edge for reads, 0 for writes; → IDLE.
  - Edge with HREADY=1, HRESP=1 → rsp_valid, rsp_err=1, rsp_rdata=0; → IDLE. The first ERROR cycle (HREADY=0, HRESP=1) is only a wait cycle; no new transfer is issued during it because HTRANS is already IDLE.
  - Counter reaches TIMEOUT_CYCLES (nonzero) while HREADY=0 → rsp_valid, rsp_timeout=1; → DRAIN.
  - If HREADY=1 on the same edge the counter reaches the limit, completion wins and there is no timeout.
- DRAIN:
  - HTRANS=IDLE; cmd_ready=0; HWDATA held.
  - Wait for an edge with HREADY=1, then → IDLE. No second response.
- Response signals:
  - rsp_valid is exactly one cycle per accepted command.
  - rsp_err/rsp_timeout/rsp_rdata are valid only with rsp_valid and are cleared to 0 otherwise.
- Latency with zero wait states: accept edge T0, NONSEQ in cycle T0+1, data phase T0+2, rsp_valid in T0+3. Throughput is one command per 3 cycles; cmd_ready is 1 during the rsp_valid cycle.
- Counter clears on entry to DATA. Width is clog2(TIMEOUT_CYCLES+1), min 1.
- Async reset mid-transfer → immediate return to reset values, with no response for the aborted command.

Test Plan:
- Write 0x4000_0000 ← 0x0000_0001, size 2, HREADY always 1 → NONSEQ one cycle after accept, HWDATA=0x1 next cycle, rsp_valid at T0+3, rsp_err=0.
- Read 0x4000_0004, slave inserts 3 wait states, HRDATA=0xDEAD_BEEF → HWDATA/HADDR stable, rsp_rdata=0xDEAD_BEEF at T0+6, single rsp_valid.
- Read with ERROR response (cycle1 HREADY=0/HRESP=1, cycle2 HREADY=1/HRESP=1) → HTRANS stays IDLE, rsp_err=1, rsp_rdata=0.
- cmd_size=2, addr=0x4000_0002 → no NONSEQ ever driven, rsp_valid+rsp_err next cycle, cmd_ready stays 1.
- TIMEOUT_CYCLES=8, HREADY held low 20 cycles → rsp_timeout after 8 low cycles, cmd_ready=0 until HREADY=1, then IDLE with no second response.
- HRESETn asserted in DATA while HREADY=0 → HTRANS=00, rsp_valid=0 immediately; the next command after release completes normally.
